spi_master: RTL and testbench

SPI controller that initiates 8-bit full-duplex transfers toward the existing SPI peripheral. It drives ss, sclk and mosi, and samples miso.
- Mode 0 only: CPOL=0, CPHA=0, MSB first; ss is active-low.
- Sits between on-chip logic, which supplies a byte and a start strobe, and the serial pins.
- Returns the received byte with a one-cycle rdy pulse.

---
 rtl/spi_master.sv | 108 ++++++++++
 tb/tb_spi_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, 8-bit full-duplex transfers, MSB first
module spi_master #(
  parameter int DIV   = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  output logic             busy,
  output logic             ss,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Last value of the half-period counter and of the bit counter.
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [2:0] BIT_LAST = 3'(WIDTH - 1);

  logic [2:0]       state;
  logic [7:0]       div_cnt;
  logic [2:0]       bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             phase_end;

  // A half-period of sclk ends when the divider has counted DIV cycles.
  assign phase_end = (div_cnt == DIV_LAST);

  // Transfer sequencer: drives ss/sclk/mosi, samples miso on each sclk rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      busy     <= 1'b0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tx_shift <= tx_data;
            ss       <= 1'b0;
            mosi     <= tx_data[WIDTH-1];
            busy     <= 1'b1;
            bit_cnt  <= 3'd0;
            div_cnt  <= 8'd0;
            state    <= S_LEAD;
          end
        end
        // The lead-in and every later low phase end the same way: sclk rises
        // and the bit the slave presented during the low phase is captured.
        S_LEAD, S_LOW: begin
          if (phase_end) begin
            div_cnt  <= 8'd0;
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[WIDTH-2:0], miso};
            state    <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            div_cnt <= 8'd0;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) begin
              state <= S_DONE;
            end else begin
              tx_shift <= tx_shift << 1;
              mosi     <= tx_shift[WIDTH-2];
              state    <= S_LOW;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_DONE: begin
          ss      <= 1'b1;
          mosi    <= 1'b0;
          busy    <= 1'b0;
          rdy     <= 1'b1;
          rx_data <= rx_shift;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master (DIV=2 and DIV=1 instances)
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_d2 = 1'b0, start_d1 = 1'b0;
  logic [7:0] tx_d2 = 8'h00, tx_d1 = 8'h00;
  logic [7:0] rx_d2, rx_d1;
  logic       rdy_d2, rdy_d1, busy_d2, busy_d1, ss_d2, ss_d1;
  logic       sclk_d2, sclk_d1, mosi_d2, mosi_d1, miso_d2, miso_d1;

  // Bench-side slave: either a wire loopback or a shift register that
  // shifts on sclk fall and captures mosi on sclk rise.
  logic       loop_en = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] slave_sr = 8'h00;
  logic [7:0] slave_cap = 8'h00;

  assign miso_d2 = loop_en ? mosi_d2 : slave_sr[7];
  assign miso_d1 = loop_en ? mosi_d1 : slave_sr[7];

  spi_master #(.DIV(2), .WIDTH(8)) dut_d2 (
    .clk(clk), .rst(rst), .start(start_d2), .tx_data(tx_d2), .rx_data(rx_d2),
    .rdy(rdy_d2), .busy(busy_d2), .ss(ss_d2), .sclk(sclk_d2), .mosi(mosi_d2), .miso(miso_d2)
  );

  spi_master #(.DIV(1), .WIDTH(8)) dut_d1 (
    .clk(clk), .rst(rst), .start(start_d1), .tx_data(tx_d1), .rx_data(rx_d1),
    .rdy(rdy_d1), .busy(busy_d1), .ss(ss_d1), .sclk(sclk_d1), .mosi(mosi_d1), .miso(miso_d1)
  );

  logic       m_sclk, m_mosi, m_rdy, m_ss, m_busy;
  logic [7:0] m_rx;
  assign m_sclk = sel ? sclk_d1 : sclk_d2;
  assign m_mosi = sel ? mosi_d1 : mosi_d2;
  assign m_rdy  = sel ? rdy_d1  : rdy_d2;
  assign m_ss   = sel ? ss_d1   : ss_d2;
  assign m_busy = sel ? busy_d1 : busy_d2;
  assign m_rx   = sel ? rx_d1   : rx_d2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  int         rises = 0;
  bit         rise_bits[$];
  int         rise_cycles[$];
  int         rdy_cycles[$];
  logic [7:0] rdy_rx[$];
  int         mosi_glitch = 0;
  int         rdy_double = 0;
  int         rdy_bad = 0;
  bit         ss_at[int];
  logic       p_sclk = 1'b0, p_mosi = 1'b0, p_rdy = 1'b0;

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    ss_at[cyc] = m_ss;
    if (m_sclk && !p_sclk) begin
      rises++;
      rise_bits.push_back(m_mosi);
      rise_cycles.push_back(cyc);
      slave_cap = {slave_cap[6:0], m_mosi};
    end
    if (!m_sclk && p_sclk) slave_sr = {slave_sr[6:0], 1'b0};
    if (m_sclk && p_sclk && (m_mosi !== p_mosi)) mosi_glitch++;
    if (m_rdy) begin
      rdy_cycles.push_back(cyc);
      rdy_rx.push_back(m_rx);
      if (p_rdy) rdy_double++;
      if (m_busy || !m_ss || m_mosi || m_sclk) rdy_bad++;
    end
    p_sclk = m_sclk;
    p_mosi = m_mosi;
    p_rdy  = m_rdy;
  end

  task automatic clear_mon();
    rises = 0;
    rise_bits.delete();
    rise_cycles.delete();
    rdy_cycles.delete();
    rdy_rx.delete();
    ss_at.delete();
    mosi_glitch = 0;
    rdy_double  = 0;
    rdy_bad     = 0;
    slave_cap   = 8'h00;
  endtask

  // Reference: byte seen on mosi at eight successive sclk rises, MSB first.
  function automatic logic [7:0] byte_from_bits(int off);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++)
      b = {b[6:0], (rise_bits.size() > off + i) ? rise_bits[off + i] : 1'b0};
    return b;
  endfunction

  // Reference: k-th rise (k=1..8) is due (2k-1)*DIV cycles after acceptance.
  function automatic int timing_errs(int t0, int div);
    int n = 0;
    for (int k = 1; k <= 8; k++)
      if (rise_cycles.size() < k || rise_cycles[k-1] != t0 + (2 * k - 1) * div) n++;
    return n;
  endfunction

  task automatic begin_xfer(input logic [7:0] tx, output int t0);
    if (sel) begin start_d1 = 1'b1; tx_d1 = tx; end
    else     begin start_d2 = 1'b1; tx_d2 = tx; end
    t0 = cyc + 1;
    @(negedge clk);
    start_d1 = 1'b0;
    start_d2 = 1'b0;
  endtask

  task automatic wait_rdy(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rdy_cycles.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (rdy_cycles.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ss_d2 !== 1'b1)   begin errors++; $display("FAIL reset_ss got=%b want=1", ss_d2); end
    checks++; if (sclk_d2 !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b want=0", sclk_d2); end
    checks++; if (mosi_d2 !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b want=0", mosi_d2); end
    checks++; if (busy_d2 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_d2); end
    checks++; if (rdy_d2 !== 1'b0)  begin errors++; $display("FAIL reset_rdy got=%b want=0", rdy_d2); end
    checks++; if (rx_d2 !== 8'h00)  begin errors++; $display("FAIL reset_rx got=%h want=00", rx_d2); end
    checks++; if (ss_d1 !== 1'b1 || sclk_d1 !== 1'b0) begin errors++; $display("FAIL reset_d1 got ss=%b sclk=%b want ss=1 sclk=0", ss_d1, sclk_d1); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t0;
    sel = 1'b0; loop_en = 1'b1; clear_mon();
    begin_xfer(8'($urandom), t0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cyc != t0 + 9) begin errors++; $display("FAIL rstmid_edge got=%0d want=%0d", cyc, t0 + 9); end
    checks++; if (ss_d2 !== 1'b1 || sclk_d2 !== 1'b0 || busy_d2 !== 1'b0)
      begin errors++; $display("FAIL rstmid_abort got ss=%b sclk=%b busy=%b want 1 0 0", ss_d2, sclk_d2, busy_d2); end
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (rdy_cycles.size() != 0) begin errors++; $display("FAIL rstmid_rdy got=%0d pulses want=0", rdy_cycles.size()); end
    checks++; if (rx_d2 !== 8'h00) begin errors++; $display("FAIL rstmid_rx got=%h want=00", rx_d2); end
    checks++; if (ss_d2 !== 1'b1 || sclk_d2 !== 1'b0) begin errors++; $display("FAIL rstmid_idle got ss=%b sclk=%b want 1 0", ss_d2, sclk_d2); end
  endtask

  task automatic test_loopback();
    int t0; bit ok;
    sel = 1'b0; loop_en = 1'b1; clear_mon();
    begin_xfer(8'h5B, t0);
    checks++; if (m_busy !== 1'b1 || m_ss !== 1'b0) begin errors++; $display("FAIL lb_start got busy=%b ss=%b want 1 0", m_busy, m_ss); end
    wait_rdy(1, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lb_timeout got no rdy want rdy"); end
    checks++; if (rdy_cycles[0] != t0 + 33) begin errors++; $display("FAIL lb_latency got=%0d want=%0d", rdy_cycles[0] - t0, 33); end
    checks++; if (rises != 8) begin errors++; $display("FAIL lb_rises got=%0d want=8", rises); end
    checks++; if (byte_from_bits(0) !== 8'h5B) begin errors++; $display("FAIL lb_mosi got=%h want=5b", byte_from_bits(0)); end
    checks++; if (m_rx !== 8'h5B) begin errors++; $display("FAIL lb_rx got=%h want=5b", m_rx); end
    checks++; if (timing_errs(t0, 2) != 0) begin errors++; $display("FAIL lb_timing got=%0d bad rises want=0", timing_errs(t0, 2)); end
    checks++; if (mosi_glitch != 0 || rdy_bad != 0) begin errors++; $display("FAIL lb_pins got glitch=%0d rdy_bad=%0d want 0 0", mosi_glitch, rdy_bad); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_slave();
    int t0; bit ok;
    sel = 1'b0; loop_en = 1'b0; clear_mon();
    slave_sr = 8'hA6;
    begin_xfer(8'h3C, t0);
    wait_rdy(1, 60, ok);
    checks++; if (!ok || rdy_cycles[0] != t0 + 33) begin errors++; $display("FAIL slv_latency got=%0d want=33", rdy_cycles[0] - t0); end
    checks++; if (m_rx !== 8'hA6) begin errors++; $display("FAIL slv_rx got=%h want=a6", m_rx); end
    checks++; if (slave_cap !== 8'h3C) begin errors++; $display("FAIL slv_cap got=%h want=3c", slave_cap); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_start();
    int t0; bit ok; logic [7:0] tx;
    sel = 1'b0; loop_en = 1'b1; clear_mon();
    tx = 8'($urandom_range(0, 254));
    begin_xfer(tx, t0);
    repeat (4) @(negedge clk);
    start_d2 = 1'b1; tx_d2 = 8'hFF;
    @(negedge clk);
    start_d2 = 1'b0;
    wait_rdy(1, 60, ok);
    repeat (40) @(negedge clk);
    checks++; if (rdy_cycles.size() != 1) begin errors++; $display("FAIL busy_rdycount got=%0d want=1", rdy_cycles.size()); end
    checks++; if (rdy_cycles[0] != t0 + 33) begin errors++; $display("FAIL busy_latency got=%0d want=33", rdy_cycles[0] - t0); end
    checks++; if (byte_from_bits(0) !== tx || rises != 8) begin errors++; $display("FAIL busy_mosi got=%h rises=%0d want=%h rises=8", byte_from_bits(0), rises, tx); end
    checks++; if (m_rx !== tx) begin errors++; $display("FAIL busy_rx got=%h want=%h", m_rx, tx); end
  endtask

  task automatic test_back_to_back();
    int t0; bit ok; int ss_hi;
    sel = 1'b1; loop_en = 1'b1; clear_mon();
    start_d1 = 1'b1; tx_d1 = 8'h81;
    t0 = cyc + 1;
    @(negedge clk);
    tx_d1 = 8'h7E;
    wait_rdy(1, 30, ok);
    @(negedge clk);
    start_d1 = 1'b0;
    wait_rdy(2, 40, ok);
    repeat (20) @(negedge clk);
    ss_hi = 0;
    for (int c = t0 + 16; c <= t0 + 19; c++) if (ss_at.exists(c) && ss_at[c]) ss_hi++;
    checks++; if (!ok || rdy_cycles.size() != 2) begin errors++; $display("FAIL b2b_rdycount got=%0d want=2", rdy_cycles.size()); end
    checks++; if (rdy_cycles[0] != t0 + 17) begin errors++; $display("FAIL b2b_rdy1 got=%0d want=17", rdy_cycles[0] - t0); end
    checks++; if (rdy_cycles[1] != t0 + 35) begin errors++; $display("FAIL b2b_rdy2 got=%0d want=35", rdy_cycles[1] - t0); end
    checks++; if (rdy_rx[0] !== 8'h81 || rdy_rx[1] !== 8'h7E) begin errors++; $display("FAIL b2b_rx got=%h,%h want=81,7e", rdy_rx[0], rdy_rx[1]); end
    checks++; if (byte_from_bits(0) !== 8'h81 || byte_from_bits(8) !== 8'h7E || rises != 16)
      begin errors++; $display("FAIL b2b_mosi got=%h,%h rises=%0d want=81,7e rises=16", byte_from_bits(0), byte_from_bits(8), rises); end
    checks++; if (ss_hi != 1) begin errors++; $display("FAIL b2b_ss_gap got=%0d want=1", ss_hi); end
    checks++; if (rdy_double != 0 || mosi_glitch != 0 || rdy_bad != 0)
      begin errors++; $display("FAIL b2b_pins got dbl=%0d glitch=%0d bad=%0d want 0 0 0", rdy_double, mosi_glitch, rdy_bad); end
    checks++; if (timing_errs(t0, 1) != 0) begin errors++; $display("FAIL b2b_timing got=%0d bad rises want=0", timing_errs(t0, 1)); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int t0; bit ok; int div; logic [7:0] tx, pre, want_rx;
    for (int it = 0; it < 10; it++) begin
      sel     = 1'($urandom_range(0, 1));
      loop_en = 1'($urandom_range(0, 1));
      div     = sel ? 1 : 2;
      tx      = 8'($urandom);
      pre     = 8'($urandom);
      want_rx = loop_en ? tx : pre;
      @(negedge clk);
      clear_mon();
      slave_sr = pre;
      begin_xfer(tx, t0);
      wait_rdy(1, 16 * div + 10, ok);
      checks++; if (!ok || rdy_cycles[0] != t0 + 16 * div + 1)
        begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", it, rdy_cycles[0] - t0, 16 * div + 1); end
      checks++; if (m_rx !== want_rx) begin errors++; $display("FAIL rnd%0d_rx got=%h want=%h", it, m_rx, want_rx); end
      checks++; if (byte_from_bits(0) !== tx || rises != 8)
        begin errors++; $display("FAIL rnd%0d_mosi got=%h rises=%0d want=%h rises=8", it, byte_from_bits(0), rises, tx); end
      checks++; if (timing_errs(t0, div) != 0 || mosi_glitch != 0 || rdy_bad != 0)
        begin errors++; $display("FAIL rnd%0d_timing got bad=%0d glitch=%0d rdy_bad=%0d want 0", it, timing_errs(t0, div), mosi_glitch, rdy_bad); end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      checks++; if (m_rx !== want_rx) begin errors++; $display("FAIL rnd%0d_hold got=%h want=%h", it, m_rx, want_rx); end
    end
    sel = 1'b0;
    loop_en = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid();
    test_loopback();
    test_slave();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
